tusca_tx_config: RTL and testbench



---
 rtl/tusca_tx_config.sv | 189 ++++++++++++++++++
 tb/tb_tusca_tx_config.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tusca_tx_config.sv
`timescale 1ns/1ps
// tusca_tx_config: UART 8N1 frame sender for the TUSCA config link.
// Frame = HEADER, 5 limits (hi/lo), XOR checksum.
//
// Ports:
//   clock, reset    : system clock, sync active-high reset
//   enviar          : one-cycle send request (INICIAL only)
//   lim_temp1..4    : temperature limits, sampled on accept
//   lim_umidade     : humidity limit, sampled on accept
//   tx_serial       : UART line, idle high
//   ocupado         : frame in progress (accept .. pronto)
//   pronto          : one-cycle end-of-frame pulse
//   db_estado       : FSM state code
module tusca_tx_config #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  HEADER       = 8'h43
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enviar,
  input  logic [15:0] lim_temp1,
  input  logic [15:0] lim_temp2,
  input  logic [15:0] lim_temp3,
  input  logic [15:0] lim_temp4,
  input  logic [15:0] lim_umidade,
  output logic        tx_serial,
  output logic        ocupado,
  output logic        pronto,
  output logic [2:0]  db_estado
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TICK_MAX =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_BYTE = 4'd11;

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    CARREGA = 3'd1,
    START   = 3'd2,
    DADOS   = 3'd3,
    STOP    = 3'd4,
    FINAL   = 3'd5
  } state_t;

  state_t state;
  state_t state_nx;

  // Snapshot, MSB-first in frame order:
  // temp1, temp2, temp3, temp4, umidade.
  logic [79:0]   snap;
  logic [3:0]    byte_idx;
  logic [2:0]    bit_idx;
  logic [CW-1:0] tick;
  logic [7:0]    shreg;
  logic [7:0]    csum;
  logic [7:0]    byte_cur;
  logic          last_tick;
  logic          bit_phase;

  assign last_tick = (tick == TICK_MAX);

  assign bit_phase = (state == START) ||
                     (state == DADOS) ||
                     (state == STOP);

  always_comb begin
    csum = 8'h00;
    for (int k = 0; k < 10; k++) begin
      csum = csum ^ snap[k*8 +: 8];
    end
  end

  always_comb begin
    byte_cur = HEADER;
    unique case (byte_idx)
      4'd0:    byte_cur = HEADER;
      4'd1:    byte_cur = snap[79:72];
      4'd2:    byte_cur = snap[71:64];
      4'd3:    byte_cur = snap[63:56];
      4'd4:    byte_cur = snap[55:48];
      4'd5:    byte_cur = snap[47:40];
      4'd6:    byte_cur = snap[39:32];
      4'd7:    byte_cur = snap[31:24];
      4'd8:    byte_cur = snap[23:16];
      4'd9:    byte_cur = snap[15:8];
      4'd10:   byte_cur = snap[7:0];
      4'd11:   byte_cur = csum;
      default: byte_cur = HEADER;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INICIAL;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      INICIAL: begin
        if (enviar) state_nx = CARREGA;
      end
      CARREGA: state_nx = START;
      START: begin
        if (last_tick) state_nx = DADOS;
      end
      DADOS: begin
        if (last_tick && bit_idx == 3'd7)
          state_nx = STOP;
      end
      STOP: begin
        if (last_tick) begin
          if (byte_idx == LAST_BYTE)
            state_nx = FINAL;
          else
            state_nx = CARREGA;
        end
      end
      FINAL:   state_nx = INICIAL;
      default: state_nx = INICIAL;
    endcase
  end

  // Datapath: snapshot, byte/bit/tick counters,
  // shift register.
  always_ff @(posedge clock) begin
    if (reset) begin
      snap     <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      tick     <= '0;
      shreg    <= '0;
    end else begin
      if (bit_phase) begin
        tick <= last_tick ? '0 : tick + CW'(1);
      end else begin
        tick <= '0;
      end

      if (state == INICIAL && enviar) begin
        snap <= {lim_temp1, lim_temp2,
                 lim_temp3, lim_temp4,
                 lim_umidade};
        byte_idx <= '0;
      end

      if (state == CARREGA) begin
        shreg   <= byte_cur;
        bit_idx <= '0;
      end

      if (state == DADOS && last_tick) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      if (state == STOP && last_tick &&
          byte_idx != LAST_BYTE) begin
        byte_idx <= byte_idx + 4'd1;
      end
    end
  end

  // Outputs
  always_comb begin
    tx_serial = 1'b1;
    ocupado   = 1'b1;
    pronto    = 1'b0;
    unique case (state)
      INICIAL: ocupado   = 1'b0;
      CARREGA: tx_serial = 1'b1;
      START:   tx_serial = 1'b0;
      DADOS:   tx_serial = shreg[0];
      STOP:    tx_serial = 1'b1;
      FINAL:   pronto    = 1'b1;
      default: ocupado   = 1'b0;
    endcase
  end

  assign db_estado = state;

endmodule

// File: tb/tb_tusca_tx_config.sv
`timescale 1ns/1ps
// tb_tusca_tx_config: scoreboard bench for the
// config transmitter; decodes the UART line.
module tb_tusca_tx_config;

  localparam int C     = 4;
  localparam int F     = 1 + 10 * C;
  localparam int FRAME = 12 * F;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enviar = 1'b1;
  logic [15:0] lt1 = '0;
  logic [15:0] lt2 = '0;
  logic [15:0] lt3 = '0;
  logic [15:0] lt4 = '0;
  logic [15:0] lu  = '0;
  logic        tx_serial;
  logic        ocupado;
  logic        pronto;
  logic [2:0]  db_estado;

  always #5 clock = ~clock;

  tusca_tx_config #(
    .CLKS_PER_BIT(C),
    .HEADER(8'h43)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enviar(enviar),
    .lim_temp1(lt1),
    .lim_temp2(lt2),
    .lim_temp3(lt3),
    .lim_temp4(lt4),
    .lim_umidade(lu),
    .tx_serial(tx_serial),
    .ocupado(ocupado),
    .pronto(pronto),
    .db_estado(db_estado)
  );

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t bq[$];
  int   pq[$];

  int cyc = 0;
  bit rst_q = 1'b0;
  int busy_lo = 1;
  int busy_hi = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic check(input bit ok,
                       input string name,
                       input longint act,
                       input longint req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  // Monitor: line decoder + ocupado/pronto scoreboard
  initial begin
    bit         mon_en;
    bit         dec_busy;
    int         dec_s;
    int         off;
    int         p;
    bit         exp_busy;
    logic [7:0] dec_d;
    exp_t       e;
    mon_en   = 1'b0;
    dec_busy = 1'b0;
    dec_s    = 0;
    dec_d    = '0;
    forever begin
      @(negedge clock);
      if (rst_q) begin
        mon_en = 1'b1;
        check(tx_serial == 1'b1, "rst_tx",
              tx_serial, 1);
        check(ocupado == 1'b0, "rst_ocupado",
              ocupado, 0);
        check(pronto == 1'b0, "rst_pronto",
              pronto, 0);
        check(db_estado == 3'd0, "rst_estado",
              db_estado, 0);
        bq.delete();
        pq.delete();
        dec_busy = 1'b0;
      end else if (mon_en) begin
        exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
        check(ocupado == exp_busy, "ocupado",
              ocupado, exp_busy);
        if (!exp_busy) begin
          check(tx_serial == 1'b1, "idle_tx",
                tx_serial, 1);
          check(db_estado == 3'd0, "idle_estado",
                db_estado, 0);
        end
        if (pronto) begin
          if (pq.size() == 0) begin
            check(1'b0, "pronto_unexpected", 1, 0);
          end else begin
            p = pq.pop_front();
            check(p == cyc, "pronto_cycle", cyc, p);
            check(db_estado == 3'd5, "final_estado",
                  db_estado, 5);
          end
        end else if (pq.size() > 0 && pq[0] < cyc) begin
          check(1'b0, "pronto_missing", cyc, pq[0]);
          void'(pq.pop_front());
        end
        if (!dec_busy) begin
          if (tx_serial == 1'b0) begin
            dec_busy = 1'b1;
            dec_s    = cyc;
            dec_d    = '0;
            if (bq.size() == 0)
              check(1'b0, "start_unexpected", cyc, 0);
            else
              check(bq[0].start == cyc, "start_cycle",
                    cyc, bq[0].start);
          end
        end else begin
          off = cyc - dec_s;
          if (off == C / 2)
            check(tx_serial == 1'b0, "start_bit",
                  tx_serial, 0);
          for (int i = 0; i < 8; i++) begin
            if (off == C * (1 + i) + C / 2)
              dec_d[i] = tx_serial;
          end
          if (off == 9 * C + C / 2) begin
            check(tx_serial == 1'b1, "stop_bit",
                  tx_serial, 1);
            if (bq.size() > 0) begin
              e = bq.pop_front();
              check(dec_d == e.data, "byte",
                    dec_d, e.data);
            end
            dec_busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives enviar for one cycle; the model decides
  // whether the DUT is free to accept it.
  task automatic send(input logic [15:0] a,
                      input logic [15:0] b,
                      input logic [15:0] c,
                      input logic [15:0] d,
                      input logic [15:0] u);
    int         cc;
    logic [15:0] w[5];
    logic [7:0]  fr[12];
    logic [7:0]  x;
    cc = cyc;
    enviar = 1'b1;
    lt1 = a; lt2 = b; lt3 = c; lt4 = d; lu = u;
    if (cc > busy_hi && !reset) begin
      w[0] = a; w[1] = b; w[2] = c;
      w[3] = d; w[4] = u;
      fr[0] = 8'h43;
      x = 8'h00;
      for (int k = 0; k < 5; k++) begin
        fr[1 + 2 * k] = 8'(w[k] / 256);
        fr[2 + 2 * k] = 8'(w[k] % 256);
        x = x ^ fr[1 + 2 * k] ^ fr[2 + 2 * k];
      end
      fr[11] = x;
      for (int k = 0; k < 12; k++)
        bq.push_back('{fr[k], cc + 2 + k * F});
      pq.push_back(cc + 1 + FRAME);
      busy_lo = cc + 1;
      busy_hi = cc + 1 + FRAME;
    end
    tick();
    enviar = 1'b0;
  endtask

  task automatic send_rand();
    send(16'($urandom), 16'($urandom),
         16'($urandom), 16'($urandom),
         16'($urandom));
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (cyc <= busy_hi && guard < 4 * FRAME) begin
      tick();
      guard++;
    end
    check(cyc > busy_hi, "idle_timeout", cyc, busy_hi);
    repeat (2) tick();
    check(bq.size() == 0, "bytes_left", bq.size(), 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    if (busy_hi > cyc) busy_hi = cyc;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  localparam logic [15:0] B1 = 16'h0019;
  localparam logic [15:0] B2 = 16'h001E;
  localparam logic [15:0] B3 = 16'h0023;
  localparam logic [15:0] B4 = 16'h0028;
  localparam logic [15:0] B5 = 16'h0050;

  initial begin
    // reset for 2 cycles with enviar high
    repeat (2) tick();
    reset  = 1'b0;
    enviar = 1'b0;
    repeat (3) tick();

    // basic frame
    send(B1, B2, B3, B4, B5);
    wait_idle();

    // snapshot: inputs change at accept+5
    send(B1, B2, B3, B4, B5);
    repeat (4) tick();
    lt1 = '1; lt2 = '1; lt3 = '1; lt4 = '1; lu = '1;
    wait_idle();

    // busy request during byte 3 is dropped
    send_rand();
    repeat (3 * F + 10) tick();
    send_rand();
    wait_idle();

    // reset during byte 6 data bits
    send(B1, B2, B3, B4, B5);
    repeat (6 * F + C + 4) tick();
    do_reset(1);
    repeat (3) tick();
    send(B1, B2, B3, B4, B5);
    wait_idle();

    // back-to-back: enviar the cycle after pronto
    send_rand();
    begin
      int g;
      g = 0;
      while (cyc < busy_hi + 1 && g < 2 * FRAME) begin
        tick();
        g++;
      end
    end
    send_rand();
    wait_idle();

    // random frames, inputs disturbed mid-frame
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 20)) tick();
      send_rand();
      repeat ($urandom_range(1, FRAME - 10)) tick();
      lt1 = 16'($urandom); lt2 = 16'($urandom);
      lu  = 16'($urandom);
      wait_idle();
    end

    repeat (5) tick();
    check(pq.size() == 0, "pronto_left", pq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
